fact_job_ctrl: RTL
==================

# fact_job_ctrl

Sequencer for the factorial accelerator in the system. It turns an operator start request and a 4-bit operand into exactly one go/done transaction with the accelerator. It range-checks the operand, enforces a completion timeout and latches the 32-bit result and error flag. It also generates the upper/lower halfword select that the 4-digit display path uses to show the full result.

## Interface
Parameters:
- `N_MAX`, default 12: largest operand issued; above this, the error is flagged locally with no accelerator access.
- `TIMEOUT`, default 255: cycles waited for `fact_done` after go before abort; valid range 2..65535.
- `ALT_PERIOD`, default 5000: cycles per display-halfword toggle (1 s at the 5 kHz system clock).

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request level; a job is triggered on its rising edge.
- `n` in 4: operand, sampled on the triggering edge.
- `fact_go` out 1: one-cycle go pulse to the accelerator.
- `fact_n` out 4: operand to the accelerator; held stable from go until the job ends.
- `fact_done` in 1: accelerator completion; `fact_err` and `fact_result` are valid in the same cycle.
- `fact_err` in 1: accelerator error.
- `fact_result` in 32: accelerator result.
- `result` out 32: latched job result.
- `err` out 1: latched job error, including range and timeout errors.
- `timeout` out 1: the last job aborted on timeout.
- `busy` out 1: a job is in flight.
- `done` out 1: one-cycle pulse when `result`/`err` update.
- `disp_upper` out 1: 1 selects `result[31:16]` for display.

## Operation
- Edge detect: `start_q` is a flop of `start`; trigger = `start & ~start_q`. `start_q` resets to 0, so `start` high at reset release counts as an edge on the first cycle after reset.
- States:
  - IDLE:
    - Trigger with `n > N_MAX`: go to ERR.
    - Trigger with `n <= N_MAX`: load `fact_n <= n`, go to GO.
  - GO: `fact_go = 1` for this cycle only; clear the wait counter; go to WAIT.
  - WAIT:
    - `fact_done` high: latch `result <= fact_err ? 0 : fact_result`, `err <= fact_err`, `timeout <= 0`; go to IDLE.
    - `fact_done` low, counter == `TIMEOUT-1`: `result <= 0`, `err <= 1`, `timeout <= 1`; go to IDLE.
    - Otherwise: increment the counter.
  - ERR: `result <= 0`, `err <= 1`, `timeout <= 0`; go to IDLE.
- `done` pulses in the cycle after the latching transition. This is the first cycle in which the new `result` is visible.
- `busy` = state != IDLE. It is registered state decode, so it is low in the cycle `done` is high.
- Triggers outside IDLE are dropped, not queued. Holding `start` high produces one job only.
- If `fact_done` is asserted in a cycle other than WAIT, it is ignored. This covers a late done after a timeout.
- A zero result with `err=0` cannot occur from a valid accelerator. `n=0` legitimately yields 1.
- Display select:
  - A `done` pulse clears the alt counter and forces `disp_upper=0`.
  - While `result[31:16] != 0`, the alt counter counts 0..`ALT_PERIOD-1`. At wrap, `disp_upper` toggles.
  - While `result[31:16] == 0`, the alt counter holds at 0 and `disp_upper=0`.
- Widths:
  - The wait counter is 16 bits.
  - The alt counter is `$clog2(ALT_PERIOD)` bits, minimum 1.
  - The comparison `n > N_MAX` is an unsigned 4-bit compare.

## Timing
- Reset values: state IDLE, `fact_go=0`, `fact_n=0`, `result=0`, `err=0`, `timeout=0`, `busy=0`, `done=0`, `disp_upper=0`, both counters 0.
- Reset in any state, including mid-WAIT, aborts the job with no `done` pulse. A done arriving after reset is ignored.
- Cycle numbering, with the edge in cycle 0:
  - `fact_go` is high in cycle 1.
  - `fact_done` is first accepted in cycle 2.
  - A done in cycle k gives `done`/`result` in cycle k+1.
- Minimum trigger-to-`done` latency is 3 cycles.
- Range error: `done` in cycle 2.
- Timeout: `fact_done` low for cycles 2 through `TIMEOUT+1` gives `done` in cycle `TIMEOUT+2`. A done that arrives in the final wait cycle wins over the timeout.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- `n=5`, accelerator returns done with `0x00000078` 6 cycles after go:
  - one `fact_go` pulse, `fact_n=5`;
  - `result=0x78`, `err=0`, `timeout=0`;
  - `disp_upper` stays 0 for 3×`ALT_PERIOD`.
- `n=12` returning `0x1C8CFC00`:
  - `result=0x1C8CFC00`;
  - `disp_upper` toggles every `ALT_PERIOD` cycles, first to 1 exactly `ALT_PERIOD` cycles after `done`.
- `n=13`:
  - no `fact_go`;
  - `done` in cycle 2, `result=0`, `err=1`, `timeout=0`.
- Accelerator never asserts done, `TIMEOUT=20`:
  - `done` in cycle 22 with `err=1`, `timeout=1`;
  - a later `fact_done` pulse produces no `done` and no change.
- `start` held high 100 cycles, with a re-edge while `busy`:
  - exactly one `fact_go`;
  - an edge during WAIT is dropped;
  - a new edge after `done` starts a second job and clears `timeout`.
- `rst` asserted for 1 cycle mid-WAIT:
  - all outputs return to reset values;
  - a subsequent `fact_done` is ignored, and the next `n=3` job gives `result=6`.

Source files
------------

// File: rtl/fact_job_ctrl.sv
// Job sequencer for the factorial accelerator. It range-checks the operand, runs one go/done
// handshake with a timeout, latches the result, and drives the display halfword select.
module fact_job_ctrl #(
    parameter int unsigned N_MAX      = 12,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned ALT_PERIOD = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  n,
    output logic        fact_go,
    output logic [3:0]  fact_n,
    input  logic        fact_done,
    input  logic        fact_err,
    input  logic [31:0] fact_result,
    output logic [31:0] result,
    output logic        err,
    output logic        timeout,
    output logic        busy,
    output logic        done,
    output logic        disp_upper
);

    localparam int unsigned WAIT_W = 16;
    localparam int unsigned ALT_W  = (ALT_PERIOD > 1) ? $clog2(ALT_PERIOD) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GO,
        S_WAIT,
        S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic                start_q;
    logic                fact_go_q, fact_go_d;
    logic [3:0]          fact_n_q, fact_n_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]         result_q, result_d;
    logic                err_q, err_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ALT_W-1:0]    alt_cnt_q, alt_cnt_d;
    logic                disp_upper_q, disp_upper_d;
    logic                trig;

    assign trig = start & ~start_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            fact_go_q    <= 1'b0;
            fact_n_q     <= 4'd0;
            wait_cnt_q   <= '0;
            result_q     <= 32'd0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            alt_cnt_q    <= '0;
            disp_upper_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            fact_go_q    <= fact_go_d;
            fact_n_q     <= fact_n_d;
            wait_cnt_q   <= wait_cnt_d;
            result_q     <= result_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            alt_cnt_q    <= alt_cnt_d;
            disp_upper_q <= disp_upper_d;
        end
    end

    // Job sequencing; go and done are produced one state early so they leave the flops on time.
    always_comb begin
        state_d    = state_q;
        fact_go_d  = 1'b0;
        fact_n_d   = fact_n_q;
        wait_cnt_d = wait_cnt_q;
        result_d   = result_q;
        err_d      = err_q;
        timeout_d  = timeout_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    if (n > 4'(N_MAX)) begin
                        state_d = S_ERR;
                    end else begin
                        fact_n_d  = n;
                        fact_go_d = 1'b1;
                        state_d   = S_GO;
                    end
                end
            end
            S_GO: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (fact_done) begin
                    result_d  = fact_err ? 32'd0 : fact_result;
                    err_d     = fact_err;
                    timeout_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    result_d  = 32'd0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_ERR: begin
                result_d  = 32'd0;
                err_d     = 1'b1;
                timeout_d = 1'b0;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Display halfword alternation; restarts on the edge that publishes a new result.
    always_comb begin
        alt_cnt_d    = alt_cnt_q;
        disp_upper_d = disp_upper_q;
        if (done_d || (result_q[31:16] == 16'd0)) begin
            alt_cnt_d    = '0;
            disp_upper_d = 1'b0;
        end else if (alt_cnt_q == ALT_W'(ALT_PERIOD - 1)) begin
            alt_cnt_d    = '0;
            disp_upper_d = ~disp_upper_q;
        end else begin
            alt_cnt_d = alt_cnt_q + ALT_W'(1);
        end
    end

    assign fact_go    = fact_go_q;
    assign fact_n     = fact_n_q;
    assign result     = result_q;
    assign err        = err_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign disp_upper = disp_upper_q;

endmodule
